updown_counter: RTL and testbench

Parametrised up/down counter with programmable modulo limit, parallel load, wrap or saturate mode, terminal-count pulse and sticky overflow flag. It is the general-purpose successor to the team's basic n-bit incrementing counter. It serves as the event counter, timer and divider primitive for control blocks that need direction, preset and bounded ranges.

---
 rtl/updown_counter_if.sv | 26 ++
 rtl/updown_counter.sv | 102 ++++++++++
 tb/tb_updown_counter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/updown_counter_if.sv
// Handshake-free control/status bundle for updown_counter.
// master drives controls and observes count/tc/ovf; slave is the counter.
interface updown_counter_if #(
    parameter int BITSIZE = 8
);
    logic               en;
    logic               up;
    logic               load;
    logic [BITSIZE-1:0] loadVal;
    logic [BITSIZE-1:0] limit;
    logic               satMode;
    logic               clrFlag;
    logic [BITSIZE-1:0] countReg;
    logic               tc;
    logic               ovf;

    modport master (
        output en, up, load, loadVal, limit, satMode, clrFlag,
        input  countReg, tc, ovf
    );

    modport slave (
        input  en, up, load, loadVal, limit, satMode, clrFlag,
        output countReg, tc, ovf
    );
endinterface

// File: rtl/updown_counter.sv
// Up/down modulo counter with load, wrap/saturate, tc pulse and sticky ovf.
// Optional prescaler enabled by defining UPDOWN_COUNTER_PRESCALE_EN.
module updown_counter #(
    parameter int BITSIZE  = 8,
    parameter int PRESCALE = 4
) (
    input logic              CLK,
    input logic              RST,
    updown_counter_if.slave  bus
);
    logic [BITSIZE-1:0] cnt_q, cnt_d;
    logic               tc_q, tc_d;
    logic               ovf_q, ovf_d;
    logic               step;

    if (BITSIZE < 2 || PRESCALE < 2) begin : g_bad_params
    end

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    localparam int PW = $clog2(PRESCALE);

    logic [PW-1:0] psc_q, psc_d;
    logic          psc_last;

    assign psc_last = (psc_q == PW'(PRESCALE - 1));
    assign step     = bus.en & psc_last;

    always_comb begin
        psc_d = psc_q;
        if (bus.load)
            psc_d = '0;
        else if (bus.en)
            psc_d = psc_last ? '0 : psc_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) psc_q <= '0;
        else     psc_q <= psc_d;
    end
`else
    assign step = bus.en;
`endif

    logic below, above, zero;
    logic up_inc, up_bnd, dn_clamp, dn_dec, dn_bnd;

    assign below    = cnt_q < bus.limit;
    assign above    = cnt_q > bus.limit;
    assign zero     = cnt_q == '0;
    assign up_inc   = bus.up & below;
    assign up_bnd   = bus.up & ~below;
    assign dn_clamp = ~bus.up & above;
    assign dn_dec   = ~bus.up & ~above & ~zero;
    assign dn_bnd   = ~bus.up & zero;

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q & ~bus.clrFlag;
        if (bus.load) begin
            cnt_d = above_load() ? bus.limit : bus.loadVal;
        end else if (step) begin
            // Boundary set is applied after clear so it wins on the same edge
            unique case (1'b1)
                up_inc:   cnt_d = cnt_q + 1'b1;
                up_bnd: begin
                    cnt_d = bus.satMode ? bus.limit : '0;
                    tc_d  = ~bus.satMode;
                    ovf_d = 1'b1;
                end
                dn_clamp: cnt_d = bus.limit;
                dn_dec:   cnt_d = cnt_q - 1'b1;
                dn_bnd: begin
                    cnt_d = bus.satMode ? '0 : bus.limit;
                    tc_d  = ~bus.satMode;
                    ovf_d = 1'b1;
                end
                default:  cnt_d = cnt_q;
            endcase
        end
    end

    function automatic logic above_load();
        return bus.loadVal > bus.limit;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.countReg = cnt_q;
    assign bus.tc       = tc_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter: a behavioural model queues the
// expected outputs per edge, each scenario task pops and compares them.
module tb_updown_counter;
    localparam int W  = 8;
    localparam int PS = 4;
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    localparam int NSTEP = PS;
`else
    localparam int NSTEP = 1;
`endif

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         tc;
        logic         ovf;
    } obs_t;

    logic CLK = 1'b0;
    logic RST;

    updown_counter_if #(.BITSIZE(W)) bus ();

    updown_counter #(.BITSIZE(W), .PRESCALE(PS)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    obs_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    int m_cnt = 0;
    int m_psc = 0;
    bit m_tc  = 1'b0;
    bit m_ovf = 1'b0;

    // Expected outputs after the coming edge, from the current inputs
    task automatic model_push();
        int lim;
        bit stp;
        bit bnd;
        obs_t e;
        lim  = int'(bus.limit);
        stp  = 1'b0;
        bnd  = 1'b0;
        m_tc = 1'b0;
        if (RST) begin
            m_cnt = 0; m_ovf = 1'b0; m_psc = 0;
        end else begin
            if (bus.load) begin
                m_cnt = (int'(bus.loadVal) > lim) ? lim : int'(bus.loadVal);
                m_psc = 0;
            end else if (bus.en) begin
`ifdef UPDOWN_COUNTER_PRESCALE_EN
                if (m_psc == PS - 1) begin stp = 1'b1; m_psc = 0; end
                else m_psc = m_psc + 1;
`else
                stp = 1'b1;
`endif
            end
            if (stp && bus.up) begin
                if (m_cnt < lim) m_cnt = m_cnt + 1;
                else begin
                    bnd = 1'b1;
                    if (bus.satMode) m_cnt = lim;
                    else begin m_cnt = 0; m_tc = 1'b1; end
                end
            end else if (stp) begin
                if (m_cnt > lim) m_cnt = lim;
                else if (m_cnt > 0) m_cnt = m_cnt - 1;
                else begin
                    bnd = 1'b1;
                    if (!bus.satMode) begin m_cnt = lim; m_tc = 1'b1; end
                end
            end
            if (bus.clrFlag) m_ovf = 1'b0;
            if (bnd) m_ovf = 1'b1;
        end
        e.cnt = W'(m_cnt);
        e.tc  = m_tc;
        e.ovf = m_ovf;
        sbq.push_back(e);
    endtask

    task automatic cycle(output obs_t got, output obs_t exp);
        model_push();
        @(posedge CLK);
        #1;
        got.cnt = bus.countReg;
        got.tc  = bus.tc;
        got.ovf = bus.ovf;
        exp = sbq.pop_front();
    endtask

    task automatic set_in(bit en, bit up, bit ld, int lv, int lim, bit sat, bit clr);
        bus.en      = en;
        bus.up      = up;
        bus.load    = ld;
        bus.loadVal = W'(lv);
        bus.limit   = W'(lim);
        bus.satMode = sat;
        bus.clrFlag = clr;
    endtask

    task automatic test_reset();
        obs_t g, e;
        RST = 1'b1;
        set_in(1, 1, 0, 0, 255, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cycle(g, e);
            checks++;
            if (g !== e || g !== '0) begin
                errors++;
                $display("FAIL reset: got %h want %h", g, e);
            end
        end
        RST = 1'b0;
        for (int i = 0; i < 5 * NSTEP; i++) begin
            cycle(g, e);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL incr[%0d]: got %h want %h", i, g, e);
            end
        end
        checks++;
        if (bus.countReg !== W'(5) || bus.tc !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL incr_final: got cnt=%0d tc=%b ovf=%b want 5 0 0",
                     bus.countReg, bus.tc, bus.ovf);
        end
    endtask

    task automatic test_wrap_up();
        obs_t g, e;
        int tcs;
        tcs = 0;
        set_in(0, 1, 1, 8, 9, 0, 0);
        cycle(g, e);
        set_in(1, 1, 0, 0, 9, 0, 0);
        for (int i = 0; i < 3 * NSTEP; i++) begin
            cycle(g, e);
            if (g.tc) tcs++;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL wrap_up[%0d]: got %h want %h", i, g, e);
            end
        end
        checks++;
        if (bus.countReg !== W'(1) || bus.ovf !== 1'b1 || tcs != 1) begin
            errors++;
            $display("FAIL wrap_up_final: got cnt=%0d ovf=%b tcs=%0d want 1 1 1",
                     bus.countReg, bus.ovf, tcs);
        end
    endtask

    task automatic test_sat_down_clear();
        obs_t g, e;
        set_in(0, 0, 1, 1, 9, 1, 1);
        cycle(g, e);
        set_in(1, 0, 0, 0, 9, 1, 0);
        for (int i = 0; i < 3 * NSTEP; i++) begin
            cycle(g, e);
            checks++;
            if (g !== e || g.tc !== 1'b0) begin
                errors++;
                $display("FAIL sat_down[%0d]: got %h want %h", i, g, e);
            end
        end
        set_in(0, 0, 0, 0, 9, 1, 1);
        cycle(g, e);
        checks++;
        if (g !== e || g.ovf !== 1'b0) begin
            errors++;
            $display("FAIL clr_flag: got %h want %h", g, e);
        end
        set_in(1, 0, 0, 0, 9, 1, 1);
        for (int i = 0; i < NSTEP; i++) begin
            cycle(g, e);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL set_wins[%0d]: got %h want %h", i, g, e);
            end
        end
        checks++;
        if (bus.ovf !== 1'b1 || bus.countReg !== '0) begin
            errors++;
            $display("FAIL set_wins_final: got ovf=%b cnt=%0d want 1 0",
                     bus.ovf, bus.countReg);
        end
    endtask

    task automatic test_load_priority();
        obs_t g, e;
        set_in(1, 1, 1, 200, 5, 0, 0);
        cycle(g, e);
        checks++;
        if (g !== e || g.cnt !== W'(5) || g.tc !== 1'b0) begin
            errors++;
            $display("FAIL load_clamp: got %h want %h", g, e);
        end
        RST = 1'b1;
        cycle(g, e);
        RST = 1'b0;
        checks++;
        if (g !== e || g !== '0) begin
            errors++;
            $display("FAIL rst_over_load: got %h want %h", g, e);
        end
    endtask

    task automatic test_limit_lowered();
        obs_t g, e;
        for (int d = 0; d < 2; d++) begin
            set_in(0, 1, 1, 7, 255, 0, 0);
            cycle(g, e);
            set_in(1, (d == 0), 0, 0, 3, 0, 0);
            for (int i = 0; i < NSTEP; i++) begin
                cycle(g, e);
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL lim_low[%0d.%0d]: got %h want %h", d, i, g, e);
                end
            end
            checks++;
            if (bus.countReg !== ((d == 0) ? W'(0) : W'(3)) || bus.tc !== (d == 0)) begin
                errors++;
                $display("FAIL lim_low_final[%0d]: got cnt=%0d tc=%b", d,
                         bus.countReg, bus.tc);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t g, e;
        int tcs;
        tcs = 0;
        set_in(0, 1, 1, 0, 0, 0, 1);
        cycle(g, e);
        set_in(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4 * NSTEP; i++) begin
            if (i == 2 * NSTEP) bus.up = 1'b0;
            cycle(g, e);
            if (g.tc) tcs++;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL b2b[%0d]: got %h want %h", i, g, e);
            end
        end
        checks++;
        if (tcs != 4) begin
            errors++;
            $display("FAIL b2b_tc_count: got %0d want 4", tcs);
        end
    endtask

    task automatic test_prescale();
        obs_t g, e;
        RST = 1'b1;
        set_in(0, 1, 0, 0, 255, 0, 0);
        cycle(g, e);
        RST = 1'b0;
        bus.en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(g, e);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL presc[%0d]: got %h want %h", i, g, e);
            end
        end
        checks++;
        if (bus.countReg !== W'(8 / NSTEP)) begin
            errors++;
            $display("FAIL presc_final: got %0d want %0d", bus.countReg, 8 / NSTEP);
        end
        for (int i = 0; i < 10; i++) begin
            bus.en = (i % 3 != 1);
            cycle(g, e);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL presc_gap[%0d]: got %h want %h", i, g, e);
            end
        end
    endtask

    task automatic test_random();
        obs_t g, e;
        for (int i = 0; i < 300; i++) begin
            RST = ($urandom_range(0, 49) == 0);
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                   $urandom_range(0, 11) == 0, $urandom_range(0, 255),
                   (i % 60 < 30) ? $urandom_range(0, 12) : 255,
                   $urandom_range(0, 1), $urandom_range(0, 7) == 0);
            cycle(g, e);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL rand[%0d]: got %h want %h", i, g, e);
            end
        end
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        set_in(0, 0, 0, 0, 255, 0, 0);
        test_reset();
        test_wrap_up();
        test_sat_down_clear();
        test_load_priority();
        test_limit_lowered();
        test_back_to_back();
        test_prescale();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
